// File: rtl/mem_line_arbiter_if.sv
// Channel-side and BRAM-side signal bundle of the line arbiter.
// The slave modport is the arbiter; the master modport is the channels and BRAM around it.
interface mem_line_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 15
);
  logic [NUM_CH-1:0]        ch_req_i;
  logic [NUM_CH-1:0]        ch_write_i;
  logic [NUM_CH*ADDR_W-1:0] ch_addr_i;
  logic [NUM_CH*LINE_W-1:0] ch_wdata_i;
  logic [LINE_W-1:0]        ch_rdata_o;
  logic [NUM_CH-1:0]        ch_ready_o;
  logic [NUM_CH-1:0]        grant_o;
  logic                     busy_o;
  logic                     mem_req_o;
  logic                     mem_write_o;
  logic [ADDR_W-1:0]        mem_addr_o;
  logic [LINE_W-1:0]        mem_wdata_o;
  logic [LINE_W-1:0]        mem_rdata_i;
  logic                     mem_valid_i;

  modport slave (
    input  ch_req_i, ch_write_i, ch_addr_i, ch_wdata_i, mem_rdata_i, mem_valid_i,
    output ch_rdata_o, ch_ready_o, grant_o, busy_o,
           mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output ch_req_i, ch_write_i, ch_addr_i, ch_wdata_i, mem_rdata_i, mem_valid_i,
    input  ch_rdata_o, ch_ready_o, grant_o, busy_o,
           mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_line_arbiter.sv
// Serialises NUM_CH line requests onto one BRAM port: grant 1 cycle after request, ready 1 cycle after mem_valid_i.
// One transaction in flight; other requesters wait for IDLE. Define MEM_ARB_ROUND_ROBIN_EN for round-robin, else fixed priority.
module mem_line_arbiter #(
  parameter int NUM_CH = 2,
  parameter int LINE_W = 128,
  parameter int ADDR_W = 15
) (
  input  logic              sys_clock,
  input  logic              reset,
  mem_line_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RELEASE
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } line_req_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] ready_q, ready_d;
  line_req_t         req_q, req_d;
  logic              mem_req_q, mem_req_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              win_vld;
  logic [IDX_W-1:0]  win_idx;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr_q;
  logic             grant_fire;
  int               idx;

  // Walk the search order backwards so the channel nearest ptr_q+1 is assigned last and wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int off = NUM_CH; off >= 1; off--) begin
      idx = (int'(ptr_q) + off) % NUM_CH;
      if (bus.ch_req_i[idx]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(idx);
      end
    end
  end

  assign grant_fire = (state_q == IDLE) && win_vld;

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      ptr_q <= IDX_W'(NUM_CH - 1);
    end else if (grant_fire) begin
      ptr_q <= win_idx;
    end
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.ch_req_i[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ready_d   = '0;
    req_d     = req_q;
    mem_req_d = mem_req_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          req_d.write      = bus.ch_write_i[win_idx];
          req_d.addr       = bus.ch_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
          req_d.wdata      = bus.ch_wdata_i[int'(win_idx)*LINE_W +: LINE_W];
          mem_req_d        = 1'b1;
          state_d          = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_valid_i) begin
          if (!req_q.write) begin
            rdata_d = bus.mem_rdata_i;
          end
          mem_req_d = 1'b0;
          ready_d   = grant_q;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ready_q   <= '0;
      req_q     <= '0;
      mem_req_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      req_q     <= req_d;
      mem_req_q <= mem_req_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.grant_o     = grant_q;
  assign bus.ch_ready_o  = ready_q;
  assign bus.ch_rdata_o  = rdata_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_write_o = req_q.write;
  assign bus.mem_addr_o  = req_q.addr;
  assign bus.mem_wdata_o = req_q.wdata;

endmodule

// File: doc/mem_line_arbiter.md
# mem_line_arbiter

N-channel arbiter that serialises line-wide (default 128-bit) read/write requests from several cache or encryption front-ends onto one single-ported BRAM line interface. It sits between the per-cache encryption/MAC units and the shared line BRAM. It replaces the ad-hoc two-way instruction/data arbitration with a parametrised, deadlock-free request/ready handshake. Each granted request is run to completion before the next one is granted.

## Interface
- NUM_CH, 2: number of requesting channels, 1..8.
- LINE_W, 128: line data width in bits.
- ADDR_W, 15: BRAM line address width in bits.

- sys_clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ch_req_i  in  NUM_CH  per-channel request level.
- ch_write_i  in  NUM_CH  per-channel write flag: 1 = write, 0 = read.
- ch_addr_i  in  NUM_CH*ADDR_W  packed addresses; channel i is bits [i*ADDR_W +: ADDR_W].
- ch_wdata_i  in  NUM_CH*LINE_W  packed write lines; channel i is bits [i*LINE_W +: LINE_W].
- ch_rdata_o  out  LINE_W  read line, shared by all channels.
- ch_ready_o  out  NUM_CH  one-cycle completion pulse per channel.
- grant_o  out  NUM_CH  one-hot owner of the current transaction.
- busy_o  out  1  high while the FSM is not in IDLE.
- mem_req_o  out  1  BRAM request level.
- mem_write_o  out  1  BRAM write flag.
- mem_addr_o  out  ADDR_W  BRAM line address.
- mem_wdata_o  out  LINE_W  BRAM write line.
- mem_rdata_i  in  LINE_W  BRAM read line; valid while mem_valid_i is high.
- mem_valid_i  in  1  BRAM completion strobe.

## Operation
- The FSM has three states: IDLE, WAIT and RELEASE.
- IDLE:
  - If any ch_req_i bit is high, pick a winner and register it as one-hot grant_o.
  - Latch the winner's write flag, address and wdata into mem_write_o, mem_addr_o and mem_wdata_o.
  - Set mem_req_o to 1 and go to WAIT.
  - If no request is high, stay in IDLE.
- WAIT:
  - mem_req_o and all mem_* attributes are held stable.
  - On mem_valid_i = 1:
    - For a read, capture mem_rdata_i into ch_rdata_o.
    - Clear mem_req_o, set ch_ready_o[granted] to 1 and go to RELEASE.
- RELEASE:
  - ch_ready_o[granted] is high for exactly this cycle.
  - grant_o stays held. ch_req_i is ignored.
  - Next state is IDLE, with ch_ready_o cleared and grant_o cleared.
- Channel rule: a channel drops ch_req_i at the clock edge that ends its ready cycle. This lets a registered drop in the channel be seen in IDLE.
- A channel keeps its req, write, addr and wdata stable from assertion until its ready pulse.
- Once a request is latched, it completes even if its ch_req_i drops early.
- ch_rdata_o holds its value until the next read capture. Writes do not change it.
- mem_valid_i is ignored in IDLE and RELEASE.

## Timing
- Reset values: mem_req_o 0, mem_write_o 0, mem_addr_o 0, mem_wdata_o 0, ch_rdata_o 0, ch_ready_o 0, grant_o 0, busy_o 0. The FSM resets to IDLE and the round-robin pointer resets to NUM_CH-1.
- Request first seen in IDLE in cycle k: mem_req_o and grant_o are high in cycle k+1.
- mem_valid_i high in cycle m: ch_ready_o and the new ch_rdata_o appear in cycle m+1. mem_req_o is low in cycle m+1.
- Minimum is 3 cycles per transaction. Back-to-back grants to different channels are possible every 3 cycles.
- Reset asserted mid-transaction aborts the transaction. Every output returns to its reset value on the next edge, and no ready pulse is issued.
- Simultaneous requests are resolved only in IDLE. A request arriving in WAIT or RELEASE waits for the next IDLE.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration. The search starts at (last granted index + 1) mod NUM_CH.
  - The pointer updates on every grant.
  - Any continuously requesting channel is granted within NUM_CH transactions.
- MEM_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; the lowest index wins. Channel 0 is the data cache by convention.
  - No pointer register is built.

## Test plan
- Single read: ch1 requests addr 0x0042, BRAM returns 0xA5…A5 one cycle after mem_req_o. Required: mem_addr_o=0x0042, mem_write_o=0, ch_ready_o=2'b10 for 1 cycle, ch_rdata_o=0xA5…A5.
- Write then read-back on ch0 at addr 0x10 with data 0x0123…CDEF. Required: mem_wdata_o matches the written line during WAIT; the following read returns 0x0123…CDEF; ch_rdata_o is unchanged by the write.
- NUM_CH=3, all channels requesting continuously:
  - With the macro, grants are 0,1,2,0,1,2.
  - Without the macro, every grant goes to ch0 and ch1/ch2 never receive ready.
- BRAM latency of 5 cycles: mem_req_o, grant_o and the mem_* attributes stay stable for all 5 cycles. Exactly one ready pulse is issued. mem_valid_i pulsed in IDLE produces no ready.
- Reset asserted in WAIT: on the next edge all outputs are 0 and no ready pulse occurs. After reset release with ch1 and ch0 both requesting, round-robin grants ch0 first.
